// File: rtl/pipelined_sat_adder.sv
// pipelined_sat_adder: group-pipelined carry-lookahead add/sub with signed saturation and valid/ready flow control
module pipelined_sat_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             carry_out
);
    localparam int NGROUPS = WIDTH / GROUP;
    localparam int L = NGROUPS - 1;
    logic             adv;
    logic [WIDTH-1:0] a_q [NGROUPS];
    logic [WIDTH-1:0] b_q [NGROUPS];
    logic [WIDTH-1:0] s_q [NGROUPS];
    logic             v_q [NGROUPS];
    logic             c_q [NGROUPS];
    logic             sat_q [NGROUPS];
    logic [WIDTH-1:0] a_i [NGROUPS];
    logic [WIDTH-1:0] b_i [NGROUPS];
    logic [WIDTH-1:0] s_i [NGROUPS];
    logic             v_i [NGROUPS];
    logic             c_i [NGROUPS];
    logic             sat_i [NGROUPS];
    // Lookahead over group k of the operands; returns {group carry out, s with group k filled in}.
    function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] x, y, s, input logic ci, input int k);
        logic [GROUP-1:0] p, g;
        logic [GROUP:0]   c;
        logic [WIDTH-1:0] r;
        p = x[k*GROUP +: GROUP] ^ y[k*GROUP +: GROUP];
        g = x[k*GROUP +: GROUP] & y[k*GROUP +: GROUP];
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) c[i+1] = g[i] | (p[i] & c[i]);
        r = s;
        r[k*GROUP +: GROUP] = p ^ c[GROUP-1:0];
        return {c[GROUP], r};
    endfunction
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    always_comb begin
        a_i[0]   = a;
        b_i[0]   = sub ? ~b : b;
        s_i[0]   = '0;
        c_i[0]   = sub;
        v_i[0]   = in_valid;
        sat_i[0] = sat_en;
        for (int k = 1; k < NGROUPS; k++) begin
            a_i[k]   = a_q[k-1];
            b_i[k]   = b_q[k-1];
            s_i[k]   = s_q[k-1];
            c_i[k]   = c_q[k-1];
            v_i[k]   = v_q[k-1];
            sat_i[k] = sat_q[k-1];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NGROUPS; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
                sat_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < NGROUPS; k++) begin
                a_q[k]             <= a_i[k];
                b_q[k]             <= b_i[k];
                {c_q[k], s_q[k]}   <= step(a_i[k], b_i[k], s_i[k], c_i[k], k);
                v_q[k]             <= v_i[k];
                sat_q[k]           <= sat_i[k];
            end
        end
    end
    // Overflow only when the operands agree in sign and the raw sum disagrees; clamp toward a's sign.
    assign out_valid = v_q[L];
    assign carry_out = c_q[L];
    assign ovf       = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
    assign result    = (sat_q[L] && ovf) ? {a_q[L][WIDTH-1], {(WIDTH-1){!a_q[L][WIDTH-1]}}} : s_q[L];
endmodule

// File: tb/tb_pipelined_sat_adder.sv
// tb_pipelined_sat_adder: directed and randomized scoreboard bench for 16/4 and 32/8 configurations
module tb_pipelined_sat_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    logic iv16, ir16, sub16, sat16, ov16, or16, ovf16, co16;
    logic [15:0] a16, b16, r16;
    logic iv32, ir32, sub32, sat32, ov32, or32, ovf32, co32;
    logic [31:0] a32, b32, r32;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_sat_adder #(.WIDTH(16), .GROUP(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .sub(sub16), .sat_en(sat16), .out_valid(ov16), .out_ready(or16),
        .result(r16), .ovf(ovf16), .carry_out(co16));
    pipelined_sat_adder #(.WIDTH(32), .GROUP(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .sub(sub32), .sat_en(sat32), .out_valid(ov32), .out_ready(or32),
        .result(r32), .ovf(ovf32), .carry_out(co32));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic on integers, returns {carry, ovf, result}.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] x, y, input logic s, st);
        longint full, half, ux, uy, sx, sy, sr, r;
        logic ov, co;
        full = longint'(1) << w;
        half = full >> 1;
        ux = longint'(x) & (full - 1);
        uy = longint'(y) & (full - 1);
        sx = (ux >= half) ? ux - full : ux;
        sy = (uy >= half) ? uy - full : uy;
        sr = s ? sx - sy : sx + sy;
        ov = (sr >= half) || (sr < -half);
        co = s ? (ux >= uy) : (ux + uy >= full);
        r = (ov && st) ? ((sr >= half) ? half - 1 : -half) : sr;
        return {co, ov, 32'(r & (full - 1))};
    endfunction

    typedef struct {
        logic [31:0] x, y;
        logic s, st;
        int c;
        bit lc, he;
        logic [33:0] ex;
    } beat_t;
    beat_t q16[$], q32[$], e16, e32;
    logic [33:0] m16, m32, ex16;
    bit lc16, he16, lc32;

    always @(negedge clk) begin
        if (rst) q16.delete();
        else begin
            if (ov16 && or16) begin
                check("pending16", 64'(q16.size() != 0), 1);
                if (q16.size() != 0) begin
                    e16 = q16.pop_front();
                    m16 = ref_op(16, e16.x, e16.y, e16.s, e16.st);
                    check("result16", 64'(r16), 64'(m16[15:0]));
                    check("ovf16", 64'(ovf16), 64'(m16[32]));
                    check("carry16", 64'(co16), 64'(m16[33]));
                    if (e16.he) check("directed16", 64'({co16, ovf16, 16'h0, r16}), 64'(e16.ex));
                    if (e16.lc) check("latency16", 64'(cyc - e16.c), 4);
                end
            end
            if (iv16 && ir16) q16.push_back('{32'(a16), 32'(b16), sub16, sat16, cyc, lc16, he16, ex16});
        end
    end

    always @(negedge clk) begin
        if (rst) q32.delete();
        else begin
            if (ov32 && or32) begin
                check("pending32", 64'(q32.size() != 0), 1);
                if (q32.size() != 0) begin
                    e32 = q32.pop_front();
                    m32 = ref_op(32, e32.x, e32.y, e32.s, e32.st);
                    check("result32", 64'(r32), 64'(m32[31:0]));
                    check("ovf32", 64'(ovf32), 64'(m32[32]));
                    check("carry32", 64'(co32), 64'(m32[33]));
                    if (e32.lc) check("latency32", 64'(cyc - e32.c), 4);
                end
            end
            if (iv32 && ir32) q32.push_back('{a32, b32, sub32, sat32, cyc, lc32, 1'b0, 34'h0});
        end
    end

    task automatic send16(input logic [15:0] x, y, input logic s, st, output int w);
        a16 = x; b16 = y; sub16 = s; sat16 = st; iv16 = 1'b1; w = 0;
        while (w < 50) begin
            @(negedge clk);
            if (ir16) break;
            w++;
            @(posedge clk); #1;
        end
        if (w >= 50) check("accept16", 64'(w), 0);
        @(posedge clk); #1;
        iv16 = 1'b0;
    endtask

    task automatic drain16();
        for (int i = 0; i < 200 && q16.size() != 0; i++) @(negedge clk);
        check("drain16", 64'(q16.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic drain32();
        for (int i = 0; i < 200 && q32.size() != 0; i++) @(negedge clk);
        check("drain32", 64'(q32.size()), 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick16();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
        return v;
    endfunction

    logic [15:0] da[5], db[5];
    logic        ds[5], dst[5];
    logic [33:0] dex[5];
    logic [33:0] held;
    int w;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        da[0] = 16'h7FFF; db[0] = 16'h0001; ds[0] = 0; dst[0] = 1; dex[0] = {1'b0, 1'b1, 32'h7FFF};
        da[1] = 16'h7FFF; db[1] = 16'h0001; ds[1] = 0; dst[1] = 0; dex[1] = {1'b0, 1'b1, 32'h8000};
        da[2] = 16'h8000; db[2] = 16'h0001; ds[2] = 1; dst[2] = 1; dex[2] = {1'b1, 1'b1, 32'h8000};
        da[3] = 16'h1234; db[3] = 16'h1234; ds[3] = 1; dst[3] = 1; dex[3] = {1'b1, 1'b0, 32'h0};
        da[4] = 16'hFFFF; db[4] = 16'h0001; ds[4] = 0; dst[4] = 1; dex[4] = {1'b1, 1'b0, 32'h0};
        rst = 1; iv16 = 0; or16 = 1; a16 = 0; b16 = 0; sub16 = 0; sat16 = 0;
        iv32 = 0; or32 = 1; a32 = 0; b32 = 0; sub32 = 0; sat32 = 0;
        lc16 = 0; he16 = 0; lc32 = 0; ex16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(ov16), 0);
        check("rst_result", 64'({co16, ovf16, r16}), 0);
        check("rst_in_ready", 64'(ir16), 1);
        @(posedge clk); #1;
        rst = 0;

        lc16 = 1; he16 = 1;
        for (int i = 0; i < 5; i++) begin
            ex16 = dex[i];
            send16(da[i], db[i], ds[i], dst[i], w);
            drain16();
        end
        he16 = 0;

        for (int i = 0; i < 8; i++) begin
            send16(pick16(), pick16(), 1'($urandom), 1'($urandom), w);
            check("b2b_ready16", 64'(w), 0);
        end
        drain16();

        lc16 = 0;
        for (int i = 0; i < 6; i++) send16(pick16(), pick16(), 1'($urandom), 1'($urandom), w);
        a16 = pick16(); b16 = pick16(); sub16 = 1'($urandom); sat16 = 1'($urandom); iv16 = 1; or16 = 0;
        @(negedge clk);
        held = {co16, ovf16, 16'h0, r16};
        check("stall_valid", 64'(ov16), 1);
        check("stall_ready", 64'(ir16), 0);
        repeat (2) begin
            @(negedge clk);
            check("stall_hold", 64'({co16, ovf16, 16'h0, r16}), 64'(held));
            check("stall_ready", 64'(ir16), 0);
        end
        @(posedge clk); #1;
        or16 = 1;
        send16(a16, b16, sub16, sat16, w);
        send16(pick16(), pick16(), 1'($urandom), 1'($urandom), w);
        drain16();

        for (int i = 0; i < 3; i++) send16(pick16(), pick16(), 1'($urandom), 1'($urandom), w);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("rst_flush_valid", 64'(ov16), 0);
        repeat (8) begin
            @(negedge clk);
            check("rst_no_ghost", 64'(ov16), 0);
        end
        @(posedge clk); #1;
        lc16 = 1;
        send16(16'h0102, 16'h0304, 1'b0, 1'b1, w);
        drain16();

        lc16 = 0;
        for (int i = 0; i < 400; i++) begin
            a16 = pick16(); b16 = pick16(); sub16 = 1'($urandom); sat16 = 1'($urandom);
            iv16 = $urandom_range(0, 3) != 0;
            or16 = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        iv16 = 0; or16 = 1;
        drain16();

        lc32 = 1;
        for (int i = 0; i < 30; i++) begin
            a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom); sat32 = 1'($urandom); iv32 = 1;
            @(posedge clk); #1;
        end
        iv32 = 0;
        drain32();
        lc32 = 0;
        for (int i = 0; i < 400; i++) begin
            a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom); sat32 = 1'($urandom);
            if ($urandom_range(0, 3) == 0) a32 = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            iv32 = $urandom_range(0, 3) != 0;
            or32 = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        iv32 = 0; or32 = 1;
        drain32();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
